// File: rtl/wr_fifo_buf_pack.sv
// rtl/wr_fifo_buf_pack.sv - packs narrow write words into wide beats held in a FWFT beat FIFO
//
// Purpose:
//   Eight IN_WIDTH words are packed LSB-first into one OUT_WIDTH beat. Each
//   completed beat is committed into a 2^DEPTH_WIDTH entry first-word-fall-through
//   store. A flush commits a partially filled beat with the unfilled words zeroed.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   wr_en    - input word offered
//   wr_data  - input word
//   wr_vld   - block can accept a word this cycle
//   flush    - single-cycle request to commit a partial beat
//   rd_en    - consumer pops the head beat
//   rd_vld   - rd_data holds a valid beat
//   rd_data  - head beat (first-word-fall-through)
//   rd_cnt   - number of stored beats, 0 to 2^DEPTH_WIDTH

module wr_fifo_buf_pack #(
   parameter int IN_WIDTH    = 32,
   parameter int OUT_WIDTH   = 256,
   parameter int DEPTH_WIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [IN_WIDTH-1:0]    wr_data,
   output logic                   wr_vld,
   input  logic                   flush,
   input  logic                   rd_en,
   output logic                   rd_vld,
   output logic [OUT_WIDTH-1:0]   rd_data,
   output logic [DEPTH_WIDTH:0]   rd_cnt
);

   // Words 0..6 of the beat under construction; word 7 is taken straight from
   // wr_data when the beat completes, so it never needs its own storage.
   localparam int PACK_W = OUT_WIDTH - IN_WIDTH;
   localparam int DEPTH  = 1 << DEPTH_WIDTH;

   localparam logic [DEPTH_WIDTH:0]   FULL_CNT = (DEPTH_WIDTH+1)'(DEPTH);
   localparam logic [DEPTH_WIDTH:0]   CNT_ONE  = (DEPTH_WIDTH+1)'(1);
   localparam logic [DEPTH_WIDTH-1:0] PTR_ONE  = DEPTH_WIDTH'(1);

   logic [2:0]             idx_q;
   logic [PACK_W-1:0]      pack_q;
   logic                   flush_pend_q;
   logic [DEPTH_WIDTH-1:0] wr_ptr_q;
   logic [DEPTH_WIDTH-1:0] rd_ptr_q;
   logic [DEPTH_WIDTH:0]   cnt_q;
   logic [OUT_WIDTH-1:0]   mem [DEPTH];

   logic                   full;
   logic                   accept;
   logic                   beat_done;
   logic                   pend_commit;
   logic                   commit;
   logic                   flush_set;
   logic                   pop;
   logic [OUT_WIDTH-1:0]   commit_beat;

   assign full = (cnt_q == FULL_CNT);

   // Only the final word of a beat needs a free slot, so words 0..6 keep
   // flowing while the store is full. Uses registered count only, so a
   // same-cycle pop does not reach wr_vld combinationally.
   assign wr_vld = !rst && !flush_pend_q && !((idx_q == 3'd7) && full);

   assign accept      = wr_en && wr_vld;
   assign beat_done   = accept && (idx_q == 3'd7);
   assign pend_commit = flush_pend_q && !full;
   assign commit      = beat_done || pend_commit;

   // A flush whose same-cycle word completes the beat is satisfied by that
   // commit; otherwise it is remembered until there is room for the padded beat.
   assign flush_set = flush && !beat_done && ((idx_q != 3'd0) || accept);

   // Unfilled words are already zero because pack_q is cleared on every commit.
   assign commit_beat = beat_done ? {wr_data, pack_q} : {{IN_WIDTH{1'b0}}, pack_q};

   assign rd_vld  = (cnt_q != '0);
   assign pop     = rd_en && rd_vld;
   assign rd_data = rd_vld ? mem[rd_ptr_q] : '0;
   assign rd_cnt  = cnt_q;

   always_ff @(posedge clk) begin
      if (!rst && commit) begin
         mem[wr_ptr_q] <= commit_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q        <= 3'd0;
         pack_q       <= '0;
         flush_pend_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         if (commit) begin
            idx_q    <= 3'd0;
            pack_q   <= '0;
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end else if (accept) begin
            pack_q[IN_WIDTH*idx_q +: IN_WIDTH] <= wr_data;
            idx_q                              <= idx_q + 3'd1;
         end

         if (pend_commit) begin
            flush_pend_q <= 1'b0;
         end else if (flush_set) begin
            flush_pend_q <= 1'b1;
         end

         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end

         case ({commit, pop})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_wr_fifo_buf_pack.sv
// tb/tb_wr_fifo_buf_pack.sv - self-checking bench for wr_fifo_buf_pack

module tb_wr_fifo_buf_pack;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         wr_en = 1'b0;
   logic [31:0]  wr_data = '0;
   logic         wr_vld;
   logic         flush = 1'b0;
   logic         rd_en = 1'b0;
   logic         rd_vld;
   logic [255:0] rd_data;
   logic [4:0]   rd_cnt;

   int total = 0;
   int bad   = 0;

   logic [255:0] sb[$];
   logic [255:0] m_pack = '0;
   int           m_idx  = 0;
   int           pushed = 0;

   typedef struct {
      logic         wr_en;
      logic [31:0]  d;
      logic         flush;
      logic         rd_en;
      logic         e_wv;
      logic         e_rv;
      logic [4:0]   e_cnt;
      logic         chk_d;
      logic [255:0] e_d;
   } vec_t;

   vec_t vt[14];

   localparam logic [255:0] BEAT1 =
      256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
   localparam logic [255:0] FBEAT = 256'h0000000c_0000000b_0000000a;

   wr_fifo_buf_pack dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .wr_vld  (wr_vld),
      .flush   (flush),
      .rd_en   (rd_en),
      .rd_vld  (rd_vld),
      .rd_data (rd_data),
      .rd_cnt  (rd_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model sampled mid-cycle: packs accepted words, pushes whole
   // or flushed beats, and compares every pop against the oldest expected beat.
   always @(negedge clk) begin
      if (rst) begin
         m_idx  = 0;
         m_pack = '0;
         sb.delete();
      end else begin
         if (rd_en && rd_vld) begin
            if (sb.size() == 0) begin
               chk("pop_unexpected", 256'd1, 256'd0);
            end else begin
               chk("pop_data", rd_data, sb.pop_front());
            end
         end
         if (wr_en && wr_vld) begin
            m_pack[m_idx*32 +: 32] = wr_data;
            m_idx++;
            if (m_idx == 8) begin
               sb.push_back(m_pack);
               pushed++;
               m_pack = '0;
               m_idx  = 0;
            end
         end
         if (flush && m_idx != 0) begin
            sb.push_back(m_pack);
            pushed++;
            m_pack = '0;
            m_idx  = 0;
         end
      end
   end

   task automatic rst_dut();
      rst   = 1'b1;
      wr_en = 1'b0;
      flush = 1'b0;
      rd_en = 1'b0;
      step();
      step();
      chk("rst_wr_vld", wr_vld, 1'b0);
      chk("rst_rd_vld", rd_vld, 1'b0);
      chk("rst_rd_cnt", rd_cnt, 5'd0);
      chk("rst_rd_data", rd_data, 256'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_wr_vld", wr_vld, 1'b1);
   endtask

   task automatic put_words(input int n, input logic [31:0] base);
      wr_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         wr_data = base + 32'(i);
         step();
      end
      wr_en = 1'b0;
   endtask

   task automatic drain(input string nm);
      rd_en = 1'b1;
      for (int i = 0; i < 40 && rd_vld; i++) step();
      rd_en = 1'b0;
      chk({nm, "_cnt"}, rd_cnt, 5'd0);
      chk({nm, "_sb_empty"}, 256'(sb.size()), 256'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;

      for (int i = 0; i < 7; i++)
         vt[i] = '{1'b1, 32'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 256'd0};
      vt[7]  = '{1'b1, 32'd8,   1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, BEAT1};
      vt[8]  = '{1'b1, 32'hA,   1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 256'd0};
      vt[9]  = '{1'b1, 32'hB,   1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 256'd0};
      vt[10] = '{1'b1, 32'hC,   1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 256'd0};
      vt[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, FBEAT};
      vt[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b1, FBEAT};
      vt[13] = '{1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 256'd0};

      rst_dut();

      // full beat, partial flush, empty-flush no-op
      for (int i = 0; i < 14; i++) begin
         wr_en   = vt[i].wr_en;
         wr_data = vt[i].d;
         flush   = vt[i].flush;
         rd_en   = vt[i].rd_en;
         step();
         chk($sformatf("row%0d_wr_vld", i), wr_vld, vt[i].e_wv);
         chk($sformatf("row%0d_rd_vld", i), rd_vld, vt[i].e_rv);
         chk($sformatf("row%0d_rd_cnt", i), rd_cnt, vt[i].e_cnt);
         if (vt[i].chk_d) chk($sformatf("row%0d_rd_data", i), rd_data, vt[i].e_d);
      end
      wr_en = 1'b0; flush = 1'b0; rd_en = 1'b0;
      chk("table_sb_empty", 256'(sb.size()), 256'd0);

      // fill to capacity, back-pressure at idx 7, release by one pop
      rst_dut();
      put_words(128, 32'h1000);
      chk("fill_cnt", rd_cnt, 5'd16);
      put_words(7, 32'h1080);
      chk("full_idx7_wr_vld", wr_vld, 1'b0);
      wr_en   = 1'b1;
      wr_data = 32'h1087;
      step();
      chk("full_ignored_cnt", rd_cnt, 5'd16);
      chk("full_ignored_wr_vld", wr_vld, 1'b0);
      rd_en = 1'b1;
      #1;
      chk("wr_vld_no_rd_en_path", wr_vld, 1'b0);
      step();
      rd_en = 1'b0;
      chk("after_pop_cnt", rd_cnt, 5'd15);
      chk("after_pop_wr_vld", wr_vld, 1'b1);
      step();
      wr_en = 1'b0;
      chk("refill_cnt", rd_cnt, 5'd16);
      drain("fill_drain");

      // flush pending while full
      rst_dut();
      put_words(135, 32'h2000);
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      step();
      chk("pend_wr_vld", wr_vld, 1'b0);
      chk("pend_cnt", rd_cnt, 5'd16);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("pend_pop_cnt", rd_cnt, 5'd15);
      chk("pend_pop_wr_vld", wr_vld, 1'b0);
      step();
      chk("pend_commit_cnt", rd_cnt, 5'd16);
      chk("pend_commit_wr_vld", wr_vld, 1'b1);
      drain("pend_drain");

      // reset mid-beat with beats stored
      rst_dut();
      put_words(37, 32'h3000);
      chk("pre_rst_cnt", rd_cnt, 5'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_rd_vld", rd_vld, 1'b0);
      chk("mid_rst_cnt", rd_cnt, 5'd0);
      chk("mid_rst_wr_vld", wr_vld, 1'b1);
      put_words(8, 32'h4000);
      chk("clean_beat_cnt", rd_cnt, 5'd1);
      drain("rst_drain");

      // random streaming across many pointer wraps
      rst_dut();
      base  = pushed;
      wr_en = 1'b1;
      for (int c = 0; c < 30000 && (pushed - base) < 1000; c++) begin
         wr_data = $urandom;
         rd_en   = 1'($urandom_range(0, 1));
         flush   = ($urandom_range(0, 63) == 0);
         step();
      end
      wr_en = 1'b0;
      flush = 1'b0;
      chk("stream_beats_done", 256'((pushed - base) >= 1000), 256'd1);
      step();
      drain("stream_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
